axis_packet_injector: RTL and testbench



---
 rtl/axis_injector_pkg.sv | 17 +
 rtl/axis_output_slot.sv | 52 +++++
 rtl/axis_packet_injector.sv | 128 ++++++++++++
 tb/tb_axis_packet_injector.sv | 259 +++++++++++++++++++++++++
 4 files changed

// File: rtl/axis_injector_pkg.sv
// axis_injector_pkg: shared FSM state type and header packing helper for axis_packet_injector
package axis_injector_pkg;
  typedef enum logic [1:0] {S_IDLE, S_HEADER, S_PAYLOAD} inj_state_t;
  localparam int HDR_W = 128;
  localparam int HDR_LEN_LSB = 0;
  // Fields are packed contiguously from HDR_LEN_LSB: len, then source address, then sequence number.
  // Callers zero-extend each field to HDR_W, so bits above the fields stay zero.
  function automatic logic [HDR_W-1:0] pack_header(
    input logic [HDR_W-1:0] len,
    input logic [HDR_W-1:0] src,
    input logic [HDR_W-1:0] seq,
    input int               len_w,
    input int               src_w
  );
    return (len << HDR_LEN_LSB) | (src << (HDR_LEN_LSB + len_w)) | (seq << (HDR_LEN_LSB + len_w + src_w));
  endfunction
endpackage

// File: rtl/axis_output_slot.sv
// axis_output_slot: single-entry valid/ready output register carrying data, last, id and dest
// Ports: clk_usr/rst_n clock and async active-low reset; i_load/i_* beat to capture (only honoured when o_free);
//        i_tready downstream ready; o_free slot can accept a beat this cycle; o_t* registered AXIS outputs.
module axis_output_slot #(
  parameter int DATA_WIDTH = 32,
  parameter int ID_WIDTH   = 2,
  parameter int DEST_WIDTH = 2
) (
  input  logic                  clk_usr,
  input  logic                  rst_n,
  input  logic                  i_load,
  input  logic [DATA_WIDTH-1:0] i_data,
  input  logic                  i_last,
  input  logic [ID_WIDTH-1:0]   i_id,
  input  logic [DEST_WIDTH-1:0] i_dest,
  input  logic                  i_tready,
  output logic                  o_free,
  output logic                  o_tvalid,
  output logic [DATA_WIDTH-1:0] o_tdata,
  output logic                  o_tlast,
  output logic [ID_WIDTH-1:0]   o_tid,
  output logic [DEST_WIDTH-1:0] o_tdest
);
  logic                  r_valid;
  logic [DATA_WIDTH-1:0] r_data;
  logic                  r_last;
  logic [ID_WIDTH-1:0]   r_id;
  logic [DEST_WIDTH-1:0] r_dest;
  assign o_free   = !r_valid || i_tready;
  assign o_tvalid = r_valid;
  assign o_tdata  = r_data;
  assign o_tlast  = r_last;
  assign o_tid    = r_id;
  assign o_tdest  = r_dest;
  always_ff @(posedge clk_usr or negedge rst_n) begin
    if (!rst_n) begin
      r_valid <= 1'b0;
      r_data  <= '0;
      r_last  <= 1'b0;
      r_id    <= '0;
      r_dest  <= '0;
    end else if (o_free) begin
      r_valid <= i_load;
      if (i_load) begin
        r_data <= i_data;
        r_last <= i_last;
        r_id   <= i_id;
        r_dest <= i_dest;
      end
    end
  end
endmodule

// File: rtl/axis_packet_injector.sv
// axis_packet_injector: turns per-packet commands plus a payload stream into header+payload AXIS packets
// Ports: clk_usr/rst_n clock and async active-low reset; router_address source id for headers;
//        cfg_* command handshake (dest, tid, len); pld_* payload stream in; axis_in_* injection stream out;
//        pkt_count packets delivered (tlast handshakes); busy FSM active or output beat pending.
module axis_packet_injector
  import axis_injector_pkg::*;
#(
  parameter int TDATA_WIDTH    = 32,
  parameter int TDEST_WIDTH    = 2,
  parameter int TID_WIDTH      = 2,
  parameter int RTR_ADDR_WIDTH = 4,
  parameter int MAX_PKT_LEN    = 16,
  parameter int LEN_WIDTH      = $clog2(MAX_PKT_LEN + 1),
  parameter int SEQ_WIDTH      = 16
) (
  input  logic                      clk_usr,
  input  logic                      rst_n,
  input  logic [RTR_ADDR_WIDTH-1:0] router_address,
  input  logic                      cfg_valid,
  output logic                      cfg_ready,
  input  logic [TDEST_WIDTH-1:0]    cfg_dest,
  input  logic [TID_WIDTH-1:0]      cfg_tid,
  input  logic [LEN_WIDTH-1:0]      cfg_len,
  input  logic                      pld_tvalid,
  output logic                      pld_tready,
  input  logic [TDATA_WIDTH-1:0]    pld_tdata,
  output logic                      axis_in_tvalid,
  input  logic                      axis_in_tready,
  output logic [TDATA_WIDTH-1:0]    axis_in_tdata,
  output logic                      axis_in_tlast,
  output logic [TID_WIDTH-1:0]      axis_in_tid,
  output logic [TDEST_WIDTH-1:0]    axis_in_tdest,
  output logic [31:0]               pkt_count,
  output logic                      busy
);
  inj_state_t               r_state;
  inj_state_t               w_next;
  logic [LEN_WIDTH-1:0]     r_len;
  logic [LEN_WIDTH-1:0]     r_rem;
  logic [TDEST_WIDTH-1:0]   r_dest;
  logic [TID_WIDTH-1:0]     r_tid;
  logic [SEQ_WIDTH-1:0]     r_seq;
  logic [31:0]              r_pkt_count;
  logic                     w_free;
  logic                     w_load;
  logic                     w_last;
  logic [TDATA_WIDTH-1:0]   w_data;
  logic [TDATA_WIDTH-1:0]   w_hdr;
  logic [LEN_WIDTH-1:0]     w_len_clamp;
  assign w_hdr       = TDATA_WIDTH'(pack_header(HDR_W'(r_len), HDR_W'(router_address), HDR_W'(r_seq), LEN_WIDTH, RTR_ADDR_WIDTH));
  assign w_len_clamp = (cfg_len > LEN_WIDTH'(MAX_PKT_LEN)) ? LEN_WIDTH'(MAX_PKT_LEN) : cfg_len;
  assign pkt_count   = r_pkt_count;
  assign busy        = (r_state != S_IDLE) || axis_in_tvalid;
  axis_output_slot #(
    .DATA_WIDTH (TDATA_WIDTH),
    .ID_WIDTH   (TID_WIDTH),
    .DEST_WIDTH (TDEST_WIDTH)
  ) u_slot (
    .clk_usr  (clk_usr),
    .rst_n    (rst_n),
    .i_load   (w_load),
    .i_data   (w_data),
    .i_last   (w_last),
    .i_id     (r_tid),
    .i_dest   (r_dest),
    .i_tready (axis_in_tready),
    .o_free   (w_free),
    .o_tvalid (axis_in_tvalid),
    .o_tdata  (axis_in_tdata),
    .o_tlast  (axis_in_tlast),
    .o_tid    (axis_in_tid),
    .o_tdest  (axis_in_tdest)
  );
  always_ff @(posedge clk_usr or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_next;
  end
  // Payload ready follows slot freedom combinationally; valid only ever comes out of the slot register.
  always_comb begin
    w_next     = r_state;
    cfg_ready  = 1'b0;
    pld_tready = 1'b0;
    w_load     = 1'b0;
    w_data     = pld_tdata;
    w_last     = 1'b0;
    case (r_state)
      S_IDLE: begin
        cfg_ready = 1'b1;
        w_next    = cfg_valid ? S_HEADER : S_IDLE;
      end
      S_HEADER: begin
        w_load = w_free;
        w_data = w_hdr;
        w_last = (r_len == '0);
        w_next = !w_free ? S_HEADER : (r_len == '0) ? S_IDLE : S_PAYLOAD;
      end
      S_PAYLOAD: begin
        pld_tready = w_free;
        w_load     = w_free && pld_tvalid;
        w_last     = (r_rem == LEN_WIDTH'(1));
        w_next     = (w_load && w_last) ? S_IDLE : S_PAYLOAD;
      end
      default: w_next = S_IDLE;
    endcase
  end
  always_ff @(posedge clk_usr or negedge rst_n) begin
    if (!rst_n) begin
      r_len       <= '0;
      r_rem       <= '0;
      r_dest      <= '0;
      r_tid       <= '0;
      r_seq       <= '0;
      r_pkt_count <= '0;
    end else begin
      if (r_state == S_IDLE && cfg_valid) begin
        r_len  <= w_len_clamp;
        r_dest <= cfg_dest;
        r_tid  <= cfg_tid;
      end
      if (r_state == S_HEADER && w_free) begin
        r_seq <= r_seq + SEQ_WIDTH'(1);
        r_rem <= r_len;
      end
      if (r_state == S_PAYLOAD && w_load) r_rem <= r_rem - LEN_WIDTH'(1);
      if (axis_in_tvalid && axis_in_tready && axis_in_tlast) r_pkt_count <= r_pkt_count + 32'd1;
    end
  end
endmodule

// File: tb/tb_axis_packet_injector.sv
// tb_axis_packet_injector: directed and randomized checks of axis_packet_injector against a packet-level model
module tb_axis_packet_injector;
  localparam int MAXL = 16;
  localparam int LW   = 5;
  localparam int AW   = 4;
  typedef struct packed {
    logic [31:0] d;
    logic        l;
    logic [1:0]  id;
    logic [1:0]  de;
  } beat_t;
  logic        clk_usr = 1'b0;
  logic        rst_n = 1'b0;
  logic [3:0]  router_address = 4'd5;
  logic        cfg_valid = 1'b0;
  logic        cfg_ready;
  logic [1:0]  cfg_dest = '0;
  logic [1:0]  cfg_tid = '0;
  logic [LW-1:0] cfg_len = '0;
  logic        pld_tvalid = 1'b0;
  logic        pld_tready;
  logic [31:0] pld_tdata = '0;
  logic        axis_in_tvalid;
  logic        axis_in_tready = 1'b0;
  logic [31:0] axis_in_tdata;
  logic        axis_in_tlast;
  logic [1:0]  axis_in_tid;
  logic [1:0]  axis_in_tdest;
  logic [31:0] pkt_count;
  logic        busy;
  logic        w_cfg_valid = 1'b0;
  logic        w_cfg_ready;
  logic        w_pld_tready;
  logic        w_tvalid;
  logic [31:0] w_tdata;
  logic        w_tlast;
  logic [1:0]  w_tid;
  logic [1:0]  w_tdest;
  logic [31:0] w_pkt_count;
  logic        w_busy;
  int          n_cmp = 0;
  int          n_err = 0;
  beat_t       exp_q[$];
  logic [31:0] pld_q[$];
  int          model_seq = 0;
  int          model_pkts = 0;
  bit          rdy_rand = 1'b0;
  bit          rdy_force = 1'b0;
  bit          pld_rand = 1'b0;
  bit          pld_hs = 1'b0;
  bit          prev_stall = 1'b0;
  beat_t       prev_b;
  beat_t       cur_b;

  always #5 clk_usr = ~clk_usr;

  axis_packet_injector u_dut (
    .clk_usr        (clk_usr),
    .rst_n          (rst_n),
    .router_address (router_address),
    .cfg_valid      (cfg_valid),
    .cfg_ready      (cfg_ready),
    .cfg_dest       (cfg_dest),
    .cfg_tid        (cfg_tid),
    .cfg_len        (cfg_len),
    .pld_tvalid     (pld_tvalid),
    .pld_tready     (pld_tready),
    .pld_tdata      (pld_tdata),
    .axis_in_tvalid (axis_in_tvalid),
    .axis_in_tready (axis_in_tready),
    .axis_in_tdata  (axis_in_tdata),
    .axis_in_tlast  (axis_in_tlast),
    .axis_in_tid    (axis_in_tid),
    .axis_in_tdest  (axis_in_tdest),
    .pkt_count      (pkt_count),
    .busy           (busy)
  );

  // Narrow sequence counter so the wrap is reachable in a short run.
  axis_packet_injector #(.SEQ_WIDTH(3)) u_wrap (
    .clk_usr        (clk_usr),
    .rst_n          (rst_n),
    .router_address (router_address),
    .cfg_valid      (w_cfg_valid),
    .cfg_ready      (w_cfg_ready),
    .cfg_dest       (2'd0),
    .cfg_tid        (2'd0),
    .cfg_len        (5'd0),
    .pld_tvalid     (1'b0),
    .pld_tready     (w_pld_tready),
    .pld_tdata      (32'd0),
    .axis_in_tvalid (w_tvalid),
    .axis_in_tready (1'b1),
    .axis_in_tdata  (w_tdata),
    .axis_in_tlast  (w_tlast),
    .axis_in_tid    (w_tid),
    .axis_in_tdest  (w_tdest),
    .pkt_count      (w_pkt_count),
    .busy           (w_busy)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    n_cmp++;
    assert (obs === expv) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  // Packet-level model: header word from the field rules, then the payload words in order.
  task automatic send_cmd(input int dest, input int tid, input int len, input logic [31:0] base);
    int          l;
    int          t;
    logic [31:0] w;
    beat_t       b;
    l = (len > MAXL) ? MAXL : len;
    b = {32'(l) | (32'(router_address) << LW) | (32'(model_seq) << (LW + AW)), l == 0, 2'(tid), 2'(dest)};
    exp_q.push_back(b);
    for (int i = 0; i < l; i++) begin
      w = (base != 0) ? base + 32'(i) : $urandom;
      pld_q.push_back(w);
      exp_q.push_back({w, i == l - 1, 2'(tid), 2'(dest)});
    end
    model_seq = (model_seq + 1) % 65536;
    model_pkts++;
    cfg_dest  = 2'(dest);
    cfg_tid   = 2'(tid);
    cfg_len   = LW'(len);
    cfg_valid = 1'b1;
    t = 0;
    do begin
      @(negedge clk_usr);
      t++;
    end while (!cfg_ready && t < 3000);
    check("cfg_accept", 64'(cfg_ready), 64'(1));
    @(posedge clk_usr);
    #1 cfg_valid = 1'b0;
  endtask

  task automatic drain();
    int t;
    t = 0;
    while (exp_q.size() > 0 && t < 5000) begin
      @(posedge clk_usr);
      #2;
      t++;
    end
    check("drain_left", 64'(exp_q.size()), 64'(0));
    exp_q.delete();
    pld_q.delete();
    @(posedge clk_usr);
    #2;
    check("busy_idle", 64'(busy), 64'(0));
  endtask

  // Payload source and downstream ready, driven just after each rising edge.
  always begin
    @(posedge clk_usr);
    #1;
    if (pld_hs && pld_q.size() > 0) pld_q.delete(0);
    pld_tvalid     = (pld_q.size() > 0) && (!pld_rand || $urandom_range(0, 1) == 1);
    pld_tdata      = (pld_q.size() > 0) ? pld_q[0] : 32'h0;
    axis_in_tready = rdy_rand ? 1'($urandom_range(0, 1)) : rdy_force;
  end

  // Output monitor: values seen here complete a handshake on the following rising edge.
  always @(negedge clk_usr) begin
    cur_b  = {axis_in_tdata, axis_in_tlast, axis_in_tid, axis_in_tdest};
    pld_hs = rst_n && pld_tvalid && pld_tready;
    if (!rst_n) prev_stall = 1'b0;
    else begin
      if (prev_stall) check("stall_hold", 64'({axis_in_tvalid, cur_b}), 64'({1'b1, prev_b}));
      if (axis_in_tvalid && axis_in_tready) begin
        check("beat_avail", 64'(exp_q.size() > 0), 64'(1));
        if (exp_q.size() > 0) begin
          check("beat", 64'(cur_b), 64'(exp_q[0]));
          exp_q.delete(0);
        end
      end
      prev_stall = axis_in_tvalid && !axis_in_tready;
      prev_b     = cur_b;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    #12;
    check("rst_tvalid", 64'(axis_in_tvalid), 64'(0));
    check("rst_tdata", 64'(axis_in_tdata), 64'(0));
    check("rst_tlast", 64'(axis_in_tlast), 64'(0));
    check("rst_tid", 64'(axis_in_tid), 64'(0));
    check("rst_tdest", 64'(axis_in_tdest), 64'(0));
    check("rst_pkt_count", 64'(pkt_count), 64'(0));
    check("rst_cfg_ready", 64'(cfg_ready), 64'(1));
    check("rst_pld_tready", 64'(pld_tready), 64'(0));
    check("rst_busy", 64'(busy), 64'(0));
    @(posedge clk_usr);
    #1 rst_n = 1'b1;
    rdy_force = 1'b1;
    repeat (2) @(posedge clk_usr);
    #1;
    send_cmd(2, 1, 3, 32'hA);
    drain();
    check("pkt_count_first", 64'(pkt_count), 64'(model_pkts));
    send_cmd(0, 0, 0, 0);
    drain();
    send_cmd(1, 3, 31, 0);
    drain();
    check("pkt_count_directed", 64'(pkt_count), 64'(model_pkts));
    send_cmd(3, 2, 16, 0);
    repeat (5) @(posedge clk_usr);
    #3 rst_n = 1'b0;
    #1;
    check("mid_rst_tvalid", 64'(axis_in_tvalid), 64'(0));
    check("mid_rst_tdata", 64'(axis_in_tdata), 64'(0));
    check("mid_rst_tlast", 64'(axis_in_tlast), 64'(0));
    check("mid_rst_tid", 64'(axis_in_tid), 64'(0));
    check("mid_rst_tdest", 64'(axis_in_tdest), 64'(0));
    check("mid_rst_pkt_count", 64'(pkt_count), 64'(0));
    check("mid_rst_busy", 64'(busy), 64'(0));
    check("mid_rst_cfg_ready", 64'(cfg_ready), 64'(1));
    check("mid_rst_pld_tready", 64'(pld_tready), 64'(0));
    exp_q.delete();
    pld_q.delete();
    model_seq  = 0;
    model_pkts = 0;
    @(posedge clk_usr);
    #1 rst_n = 1'b1;
    rdy_rand = 1'b1;
    pld_rand = 1'b1;
    for (int k = 0; k < 100; k++)
      send_cmd(int'($urandom_range(0, 3)), int'($urandom_range(0, 3)), int'($urandom_range(1, MAXL)), 0);
    drain();
    check("pkt_count_random", 64'(pkt_count), 64'(model_pkts));
    rdy_rand = 1'b0;
    pld_rand = 1'b0;
    @(posedge clk_usr);
    #1;
    for (int k = 0; k < 10; k++) begin
      w_cfg_valid = 1'b1;
      @(posedge clk_usr);
      #1 w_cfg_valid = 1'b0;
      @(posedge clk_usr);
      @(negedge clk_usr);
      check("wrap_hdr", 64'({w_tvalid, w_tlast, w_tdata}),
            64'({1'b1, 1'b1, (32'(k % 8) << (LW + AW)) | (32'(router_address) << LW)}));
      @(posedge clk_usr);
      #1;
    end
    check("wrap_pkt_count", 64'(w_pkt_count), 64'(10));
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
